serial_pair_packer: RTL

SERIAL_PAIR_PACKER -- requirements
Module: serial_pair_packer

---
 rtl/serial_pair_packer.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_pair_packer.sv
// Packs a serial bit stream into 2-bit pairs with a frame-end flag, parity and
// a saturating per-frame pair index; odd-length frames are padded with a 0.
module serial_pair_packer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [1:0]       a,
    output logic             f,
    output logic             g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pair_idx
);

    typedef enum logic [1:0] {
        EMPTY,
        HALF,
        FULL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             hi;
    logic             started;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             in_xfer;
    logic             out_xfer;

    // In FULL the slot frees in the same cycle the pair leaves, so readiness
    // follows out_ready directly; started keeps it low until the first edge
    // after reset release.
    assign in_ready = started && ((state != FULL) || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Count of pairs already delivered in the current frame, as seen by a
    // pair formed this cycle.
    always_comb begin
        cnt_next = cnt;
        if (out_xfer) begin
            if (f) begin
                cnt_next = '0;
            end else if (cnt != CNT_MAX) begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every update in this
    // block sees the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            hi        <= 1'b0;
            started   <= 1'b0;
            cnt       <= '0;
            a         <= 2'b00;
            f         <= 1'b0;
            g         <= 1'b0;
            out_valid <= 1'b0;
            pair_idx  <= '0;
        end else begin
            started <= 1'b1;
            cnt     <= cnt_next;

            if (out_xfer) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
            end

            // An accepted bit in FULL implies out_xfer, so it follows the EMPTY rules.
            if (in_xfer) begin
                if (state == HALF) begin
                    a         <= {hi, in_bit};
                    f         <= in_last;
                    g         <= hi ^ in_bit;
                    pair_idx  <= cnt_next;
                    state     <= FULL;
                    out_valid <= 1'b1;
                end else if (in_last) begin
                    a         <= {in_bit, 1'b0};
                    f         <= 1'b1;
                    g         <= in_bit;
                    pair_idx  <= cnt_next;
                    state     <= FULL;
                    out_valid <= 1'b1;
                end else begin
                    hi    <= in_bit;
                    state <= HALF;
                end
            end
        end
    end

endmodule
